// File: rtl/spi_master_core_if.sv
// Host handshake and SPI pin bundle for spi_master_core.
// master: the SPI master core. slave: everything around it (host FSM and SPI device).
interface spi_master_core_if;
  logic [4:0]  nbits;
  logic [31:0] mosi_data;
  logic        request;
  logic        ready;
  logic [31:0] miso_data;
  logic        spi_cen;
  logic        spi_scl;
  logic        spi_sdi;
  logic        spi_sdo;

  modport master (
    input  nbits, mosi_data, request, spi_sdo,
    output ready, miso_data, spi_cen, spi_scl, spi_sdi
  );

  modport slave (
    output nbits, mosi_data, request, spi_sdo,
    input  ready, miso_data, spi_cen, spi_scl, spi_sdi
  );
endinterface

// File: rtl/spi_master_core.sv
// SPI master, mode 3 (CPOL=1, CPHA=1), MSB first, 1..32 bit frames.
// Every output is a flop; the comb processes only compute next values.
module spi_master_core #(
  parameter int CLK_DIV = 1
) (
  input  logic            clk_in,
  input  logic            reset,
  spi_master_core_if.master bus
);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_END} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [4:0]    cnt_q, cnt_d;
  logic [31:0]   tx_q, tx_d;
  logic [31:0]   rx_q, rx_d;
  logic [31:0]   miso_q, miso_d;
  logic          ready_q, ready_d;
  logic          cen_q, cen_d;
  logic          scl_q, scl_d;
  logic          sdi_q, sdi_d;
  logic          tick;
  logic          accept;

  // One SCL half-period elapses each time the divider wraps.
  assign tick   = (div_q == DW'(CLK_DIV - 1));
  assign accept = (state_q == S_IDLE) && bus.request;

  // State register.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state: a frame ends on the rising SCL edge of bit 0, then one more half-period of CEN low.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.request) state_d = S_SHIFT;
      S_SHIFT: if (tick && !scl_q && cnt_q == 5'd0) state_d = S_END;
      S_END:   if (tick) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output/datapath next values: data changes on falling SCL, sampled on rising SCL.
  always_comb begin
    div_d   = div_q;
    cnt_d   = cnt_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    miso_d  = miso_q;
    ready_d = ready_q;
    cen_d   = cen_q;
    scl_d   = scl_q;
    sdi_d   = sdi_q;
    case (state_q)
      S_IDLE: begin
        div_d = '0;
        if (accept) begin
          cnt_d   = bus.nbits;
          tx_d    = bus.mosi_data;
          rx_d    = '0;
          ready_d = 1'b0;
          cen_d   = 1'b0;
          scl_d   = 1'b1;
          sdi_d   = bus.mosi_data[bus.nbits];
        end
      end
      S_SHIFT: begin
        div_d = tick ? '0 : div_q + DW'(1);
        if (tick) begin
          if (scl_q) begin
            scl_d = 1'b0;
            sdi_d = tx_q[cnt_q];
          end else begin
            scl_d = 1'b1;
            rx_d  = {rx_q[30:0], bus.spi_sdo};
            if (cnt_q != 5'd0) cnt_d = cnt_q - 5'd1;
          end
        end
      end
      S_END: begin
        div_d = tick ? '0 : div_q + DW'(1);
        if (tick) begin
          cen_d   = 1'b1;
          ready_d = 1'b1;
          miso_d  = rx_q;
        end
      end
      default: ;
    endcase
  end

  // Datapath and pin registers; reset aborts any frame in flight.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      div_q   <= '0;
      cnt_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      miso_q  <= '0;
      ready_q <= 1'b1;
      cen_q   <= 1'b1;
      scl_q   <= 1'b1;
      sdi_q   <= 1'b0;
    end else begin
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      miso_q  <= miso_d;
      ready_q <= ready_d;
      cen_q   <= cen_d;
      scl_q   <= scl_d;
      sdi_q   <= sdi_d;
    end
  end

  assign bus.ready     = ready_q;
  assign bus.miso_data = miso_q;
  assign bus.spi_cen   = cen_q;
  assign bus.spi_scl   = scl_q;
  assign bus.spi_sdi   = sdi_q;
endmodule

// File: tb/tb_spi_master_core.sv
// Bench for spi_master_core: SPI slave model (LIS3DH WHO_AM_I, tied-1, echo) plus scoreboard.
module tb_spi_master_core;
  localparam int DIV = 1;

  typedef struct {
    logic [31:0] miso;
    logic [31:0] sdi;
    int          pulses;
    int          low;
  } exp_t;

  logic clk_in = 1'b0;
  logic reset  = 1'b1;
  always #5 clk_in = ~clk_in;

  spi_master_core_if bus();
  spi_master_core #(.CLK_DIV(DIV)) dut (.clk_in(clk_in), .reset(reset), .bus(bus));

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  // Slave model state
  int          mode = 0;          // 0 LIS3DH, 1 SDO tied high, 2 echo SDI
  logic        sdo_r = 1'b0;
  int          pulses = 0;
  logic [31:0] sdi_word = '0;
  logic [7:0]  cmd = '0;
  logic [7:0]  who_am_i = 8'h33;
  logic        prev_scl = 1'b1;
  logic        prev_cen = 1'b1;

  assign bus.spi_sdo = (mode == 1) ? 1'b1 : (mode == 2) ? bus.spi_sdi : sdo_r;

  // Mode-3 slave: sample SDI on rising SCL, update SDO after falling SCL.
  always @(bus.spi_scl or bus.spi_cen) begin
    if (!bus.spi_cen && prev_cen) begin
      pulses = 0; sdi_word = '0; cmd = '0; sdo_r = 1'b0;
    end
    if (!bus.spi_cen && bus.spi_scl && !prev_scl) begin
      sdi_word = {sdi_word[30:0], bus.spi_sdi};
      if (pulses < 8) cmd = {cmd[6:0], bus.spi_sdi};
      pulses++;
    end
    if (!bus.spi_cen && !bus.spi_scl && prev_scl) begin
      if (pulses >= 8 && pulses < 16 && cmd[7] && cmd[5:0] == 6'h0F)
        sdo_r = who_am_i[15 - pulses];
      else
        sdo_r = 1'b0;
    end
    prev_scl = bus.spi_scl;
    prev_cen = bus.spi_cen;
  end

  // One frame: push expectation, request for 'hold' edges, scramble inputs, pop and compare on ready.
  task automatic run_frame(input logic [4:0] nb, input logic [31:0] d, input logic [31:0] exp_miso,
                           input int hold, input string name);
    exp_t        e;
    exp_t        got;
    int          low;
    logic [31:0] mask;
    mask     = (nb == 5'd31) ? 32'hFFFF_FFFF : ((32'd1 << (32'(nb) + 1)) - 32'd1);
    e.miso   = exp_miso;
    e.sdi    = d & mask;
    e.pulses = int'(nb) + 1;
    e.low    = (2 * (int'(nb) + 1) + 1) * DIV;
    sb.push_back(e);
    @(negedge clk_in);
    bus.nbits = nb; bus.mosi_data = d; bus.request = 1'b1;
    @(posedge clk_in);
    low = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_in);
      if (i == 0) begin bus.nbits = ~nb; bus.mosi_data = ~d; end
      if (i == hold - 1) bus.request = 1'b0;
      if (bus.ready) break;
      low++;
    end
    bus.request = 1'b0;
    got = sb.pop_front();
    checks++;
    if (low !== got.low) begin
      errors++; $display("FAIL %s ready_low got %0d want %0d", name, low, got.low);
    end
    checks++;
    if (bus.miso_data !== got.miso) begin
      errors++; $display("FAIL %s miso_data got %h want %h", name, bus.miso_data, got.miso);
    end
    checks++;
    if (sdi_word !== got.sdi) begin
      errors++; $display("FAIL %s sdi_bits got %h want %h", name, sdi_word, got.sdi);
    end
    checks++;
    if (pulses !== got.pulses) begin
      errors++; $display("FAIL %s scl_pulses got %0d want %0d", name, pulses, got.pulses);
    end
  endtask

  task automatic check_idle(input string name, input logic [31:0] miso);
    checks++;
    if ({bus.ready, bus.spi_cen, bus.spi_scl} !== 3'b111) begin
      errors++; $display("FAIL %s rdy_cen_scl got %b want 111", name, {bus.ready, bus.spi_cen, bus.spi_scl});
    end
    checks++;
    if (bus.miso_data !== miso) begin
      errors++; $display("FAIL %s miso_data got %h want %h", name, bus.miso_data, miso);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_in);
    checks++;
    if ({bus.ready, bus.spi_cen, bus.spi_scl, bus.spi_sdi} !== 4'b1110) begin
      errors++; $display("FAIL reset_held pins got %b want 1110", {bus.ready, bus.spi_cen, bus.spi_scl, bus.spi_sdi});
    end
    reset = 1'b0;
    repeat (2) @(negedge clk_in);
    check_idle("reset_release", 32'h0);
    checks++;
    if (bus.spi_sdi !== 1'b0) begin
      errors++; $display("FAIL reset_release sdi got %b want 0", bus.spi_sdi);
    end
  endtask

  task automatic test_lis3dh();
    mode = 0;
    run_frame(5'd15, 32'h0000_8F00, 32'h0000_0033, 1, "lis3dh_whoami");
  endtask

  task automatic test_tied_high();
    mode = 1;
    run_frame(5'd7, 32'h0000_00A5, 32'h0000_00FF, 1, "byte_sdo_high");
  endtask

  task automatic test_echo32();
    mode = 2;
    run_frame(5'd31, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1, "echo32");
    repeat (5) @(negedge clk_in);
    check_idle("idle_stable", 32'hDEAD_BEEF);
  endtask

  task automatic test_hold_request();
    mode = 1;
    run_frame(5'd0, 32'h0000_0000, 32'h0000_0001, 3, "one_bit_hold");
    repeat (10) @(negedge clk_in);
    check_idle("no_second_frame", 32'h0000_0001);
    checks++;
    if (pulses !== 1) begin
      errors++; $display("FAIL no_second_frame pulses got %0d want 1", pulses);
    end
  endtask

  task automatic test_back_to_back();
    mode = 2;
    run_frame(5'd11, 32'h0000_0ABC, 32'h0000_0ABC, 1, "b2b_a");
    run_frame(5'd3, 32'hFFFF_FFF6, 32'h0000_0006, 1, "b2b_b");
  endtask

  task automatic test_reset_mid();
    int n;
    mode = 0;
    @(negedge clk_in);
    bus.nbits = 5'd15; bus.mosi_data = 32'h0000_8F00; bus.request = 1'b1;
    @(negedge clk_in);
    bus.request = 1'b0;
    n = 0;
    while (pulses != 5 && n < 100) begin @(negedge clk_in); n++; end
    checks++;
    if (pulses != 5) begin
      errors++; $display("FAIL reset_mid reach_bit5 got %0d want 5", pulses);
    end
    reset = 1'b1;
    #1;
    check_idle("reset_mid", 32'h0);
    @(negedge clk_in);
    reset = 1'b0;
    run_frame(5'd15, 32'h0000_8F00, 32'h0000_0033, 1, "after_reset");
  endtask

  initial begin
    bus.nbits = '0; bus.mosi_data = '0; bus.request = 1'b0;
    test_reset();
    test_lis3dh();
    test_tied_high();
    test_echo32();
    test_hold_request();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
